f_prefetch: RTL and testbench
=============================

# f_prefetch

Parametrised successor to the F stage. It fetches instructions from a combinational-read instruction memory into a DEPTH-entry prefetch queue, which decouples fetch from D-stage stalls. It handles D-stage redirects (branch/jump) with an optional MIPS delay slot and exception-vector redirects, and flags instruction address errors per entry. It sits between the instruction memory and the F/D pipeline register.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset
- EXC_VECTOR, 32'h0000_4180, fetch address on exception redirect
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address
- IMEM_BYTES, 32'h0000_4000, size of legal fetch window in bytes
- DEPTH, 4, queue entries; power of two, at least 2
- DELAY_SLOT, 1, 1 = keep one delay-slot instruction on redirect, 0 = flush all

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- imem_addr  output  32  current fetch PC to instruction memory
- imem_rdata  input  32  instruction at imem_addr, same cycle
- redirect_valid  input  1  D stage resolved a taken branch/jump this cycle
- redirect_pc  input  32  target for redirect_valid
- excp_valid  input  1  exception/eret redirect to EXC_VECTOR
- out_valid  output  1  queue head valid
- out_ready  input  1  D accepts head this cycle (D enable)
- out_pc  output  32  PC of head entry
- out_pc8  output  32  out_pc + 8, modulo 2^32
- out_instr  output  32  instruction of head entry
- out_adel  output  1  head entry has an instruction address error

## Operation
- State: fetch_pc (32 b), circular queue of DEPTH entries {pc, instr, adel}, head and tail pointers (log2(DEPTH) b), count (log2(DEPTH)+1 b).
- imem_addr = fetch_pc, combinationally.
- adel = (fetch_pc[1:0] != 0) or fetch_pc < IMEM_BASE or fetch_pc >= IMEM_BASE + IMEM_BYTES. The comparison is done in 33 bits so it cannot wrap.
- An adel entry stores instr = 32'h0 and sets its adel bit.
- Enqueue occurs when count < DEPTH, or when count == DEPTH and a dequeue happens in the same cycle. On enqueue, fetch_pc <= fetch_pc + 4, wrapping modulo 2^32. With no enqueue, fetch_pc holds.
- Dequeue = out_valid && out_ready. out_valid = (count != 0). The head fields are driven from the queue storage.
- Priority per edge: reset > excp_valid > redirect_valid > normal operation.
- excp_valid: flush all entries, discard this cycle's fetch, fetch_pc <= EXC_VECTOR. The DELAY_SLOT rule is ignored.
- redirect_valid with DELAY_SLOT=0: flush all entries, discard this cycle's fetch, fetch_pc <= redirect_pc.
- redirect_valid with DELAY_SLOT=1, fetch_pc <= redirect_pc in every case:
  - Queue non-empty and head not dequeued this cycle: keep the head only (count=1), discard the rest and this cycle's fetch.
  - Head dequeued this cycle: the delay slot went to D, so flush all and discard this cycle's fetch.
  - Queue empty: this cycle's fetch is the delay slot; enqueue it (count=1).
- Dequeue and enqueue in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
- A redirect with a misaligned redirect_pc is accepted. The resulting entries carry adel=1, and fetch continues sequentially until the next redirect.

## Timing
- While reset=0 at an edge: fetch_pc <= RESET_PC, count/head/tail <= 0. After that edge, out_valid=0 and out_adel=0; out_pc, out_pc8, out_instr are don't-care while out_valid=0.
- Fetch-to-visible latency is 1 cycle. A PC fetched in cycle N appears at the head in cycle N+1 if the queue was empty.
- After a redirect or exception edge, the first target-path instruction is visible the following cycle. With DELAY_SLOT=1 and a kept slot, it is visible one dequeue later.
- With out_ready held at 1 and no redirects, one instruction is delivered per cycle and the queue steady-state count is 1.
- With out_ready held at 0, the queue fills to DEPTH after DEPTH cycles, then fetch_pc stalls.
- If excp_valid and redirect_valid are asserted together, only the exception takes effect.

## Test plan
- Reset release with out_ready=1: out_pc sequence 0x3000, 0x3004, 0x3008, …, one per cycle; out_pc8 = 0x3008 for the first entry; out_valid=0 in the first cycle after reset.
- out_ready=0 for 6 cycles (DEPTH=4): count saturates at 4 and imem_addr holds at 0x3010. Then out_ready=1: entries 0x3000–0x300C drain in order with no loss or duplication, and fetch resumes at 0x3010.
- DELAY_SLOT=1: branch at 0x3008 in D with head 0x300C not dequeued, redirect_pc=0x3100. The next outputs are 0x300C then 0x3100, and 0x3010+ never appear. Repeat with the queue empty (slot fetched in the redirect cycle): same output order.
- DELAY_SLOT=0, same redirect: the next output is 0x3100.
- excp_valid and redirect_valid in the same cycle with a full queue: the queue flushes and the next output is 0x4180.
- redirect_pc=0x3102, then redirect_pc=0x0000_0000: out_adel=1 with out_instr=0 for both paths. A subsequent redirect to 0x3000 gives out_adel=0. Assert reset=0 mid-stream with a full queue: out_valid=0 the next cycle and fetch restarts at 0x3000.

Source files
------------

// File: rtl/f_prefetch.sv
// ---------------------------------------------------------------------------
// f_prefetch : instruction fetch into a DEPTH-entry prefetch queue with
//              branch/exception redirect and per-entry address-error flag.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module f_prefetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_BYTES = 32'h0000_4000,
  parameter int          DEPTH      = 4,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        excp_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc8,
  output logic [31:0] out_instr,
  output logic        out_adel
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);
  // 33-bit window bounds so base + size cannot wrap
  localparam logic [32:0] WIN_LO = {1'b0, IMEM_BASE};
  localparam logic [32:0] WIN_HI = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      ent_pc_q    [DEPTH];
  logic [31:0]      ent_instr_q [DEPTH];
  logic [DEPTH-1:0] ent_adel_q;

  logic fetch_adel;
  logic deq;
  logic wr_en;

  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = ent_pc_q[head_q];
  assign out_pc8   = ent_pc_q[head_q] + 32'd8;
  assign out_instr = ent_instr_q[head_q];
  assign out_adel  = out_valid & ent_adel_q[head_q];

  always_comb begin
    fetch_adel = (fetch_pc_q[1:0] != 2'b00) ||
                 ({1'b0, fetch_pc_q} < WIN_LO) ||
                 ({1'b0, fetch_pc_q} >= WIN_HI);
    deq        = out_valid && out_ready;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    wr_en      = 1'b0;

    if (excp_valid) begin
      fetch_pc_d = EXC_VECTOR;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      if (DELAY_SLOT && out_valid && !deq) begin
        // head is the delay slot still waiting for D
        tail_d  = head_q + ONE_PTR;
        count_d = ONE_CNT;
      end else if (DELAY_SLOT && !out_valid) begin
        // the word fetched this cycle is the delay slot
        wr_en   = 1'b1;
        tail_d  = tail_q + ONE_PTR;
        count_d = ONE_CNT;
      end else begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
    end else begin
      wr_en = (count_q != FULL_CNT) || deq;
      if (wr_en) begin
        tail_d     = tail_q + ONE_PTR;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (deq) begin
        head_d = head_q + ONE_PTR;
      end
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      ent_pc_q[tail_q]    <= fetch_pc_q;
      ent_instr_q[tail_q] <= fetch_adel ? 32'h0 : imem_rdata;
      ent_adel_q[tail_q]  <= fetch_adel;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_f_prefetch.sv
// ---------------------------------------------------------------------------
// tb_f_prefetch : directed vector bench for f_prefetch (DELAY_SLOT 1 and 0).
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_f_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        excp_valid;

  logic [31:0] d1_addr, d1_rdata, d1_pc, d1_pc8, d1_instr;
  logic        d1_valid, d1_adel;
  logic [31:0] d0_addr, d0_rdata, d0_pc, d0_pc8, d0_instr;
  logic        d0_valid, d0_adel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // instruction memory model: contents derived from address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign d1_rdata = mem_word(d1_addr);
  assign d0_rdata = mem_word(d0_addr);

  f_prefetch #(.DELAY_SLOT(1'b1)) u_ds1 (
    .clk(clk), .reset(reset), .imem_addr(d1_addr), .imem_rdata(d1_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .excp_valid(excp_valid), .out_valid(d1_valid), .out_ready(out_ready),
    .out_pc(d1_pc), .out_pc8(d1_pc8), .out_instr(d1_instr), .out_adel(d1_adel)
  );

  f_prefetch #(.DELAY_SLOT(1'b0)) u_ds0 (
    .clk(clk), .reset(reset), .imem_addr(d0_addr), .imem_rdata(d0_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .excp_valid(excp_valid), .out_valid(d0_valid), .out_ready(out_ready),
    .out_pc(d0_pc), .out_pc8(d0_pc8), .out_instr(d0_instr), .out_adel(d0_adel)
  );

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_adel;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic y, input logic rv,
                              input logic [31:0] rpc, input logic ev,
                              input logic v, input logic [31:0] pc,
                              input logic ad, input logic [31:0] addr);
    vec_t t;
    t = '{rst_n: r, rdy: y, rv: rv, rpc: rpc, ev: ev,
          e_valid: v, e_pc: pc, e_adel: ad, e_addr: addr};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic a_valid, input logic [31:0] a_pc,
                         input logic [31:0] a_pc8, input logic [31:0] a_instr,
                         input logic a_adel, input logic [31:0] a_addr,
                         input logic e_valid, input logic [31:0] e_pc,
                         input logic e_adel, input logic [31:0] e_addr);
    chk({tag, " valid"}, {31'b0, a_valid}, {31'b0, e_valid});
    chk({tag, " adel"},  {31'b0, a_adel},  {31'b0, e_valid & e_adel});
    chk({tag, " imem_addr"}, a_addr, e_addr);
    if (e_valid) begin
      chk({tag, " pc"},    a_pc,    e_pc);
      chk({tag, " pc8"},   a_pc8,   e_pc + 32'd8);
      chk({tag, " instr"}, a_instr, e_adel ? 32'h0 : mem_word(e_pc));
    end
  endtask

  task automatic drive(input logic r, input logic y, input logic rv,
                       input logic [31:0] rpc, input logic ev);
    reset          = r;
    out_ready      = y;
    redirect_valid = rv;
    redirect_pc    = rpc;
    excp_valid     = ev;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; excp_valid = 1'b0;

    // reset release, streaming
    vecs.push_back(mk(0,1,0,0,0, 0,32'h0,   0,32'h3000));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3000,0,32'h3004));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3004,0,32'h3008));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3008,0,32'h300C));
    // stall until full, then drain
    vecs.push_back(mk(0,0,0,0,0, 0,32'h0,   0,32'h3000));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h3000,0,32'h3004));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h3000,0,32'h3008));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h3000,0,32'h300C));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h3000,0,32'h3010));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h3000,0,32'h3010));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h3000,0,32'h3010));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3004,0,32'h3014));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3008,0,32'h3018));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h300C,0,32'h301C));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3010,0,32'h3020));
    // delay slot kept in queue
    vecs.push_back(mk(0,1,0,0,0, 0,32'h0,   0,32'h3000));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3000,0,32'h3004));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3004,0,32'h3008));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3008,0,32'h300C));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h300C,0,32'h3010));
    vecs.push_back(mk(1,0,1,32'h3100,0, 1,32'h300C,0,32'h3100));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3100,0,32'h3104));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3104,0,32'h3108));
    // delay slot fetched in the redirect cycle (queue empty)
    vecs.push_back(mk(0,1,0,0,0, 0,32'h0,   0,32'h3000));
    vecs.push_back(mk(1,1,1,32'h3100,0, 1,32'h3000,0,32'h3100));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3100,0,32'h3104));
    // delay slot dequeued in the redirect cycle
    vecs.push_back(mk(1,1,1,32'h3200,0, 0,32'h0,   0,32'h3200));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3200,0,32'h3204));
    // exception beats redirect on a full queue
    vecs.push_back(mk(0,0,0,0,0, 0,32'h0,   0,32'h3000));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h3000,0,32'h3004));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h3000,0,32'h3008));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h3000,0,32'h300C));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h3000,0,32'h3010));
    vecs.push_back(mk(1,0,1,32'h3100,1, 0,32'h0,   0,32'h4180));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h4180,0,32'h4184));
    // address errors: misaligned, below window, then legal/upper boundary
    vecs.push_back(mk(1,0,1,32'h3102,0, 1,32'h4180,0,32'h3102));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3102,1,32'h3106));
    vecs.push_back(mk(1,0,1,32'h0,0,    1,32'h3102,1,32'h0000));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h0000,1,32'h0004));
    vecs.push_back(mk(1,0,1,32'h3000,0, 1,32'h0000,1,32'h3000));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3000,0,32'h3004));
    vecs.push_back(mk(1,0,1,32'h6FFC,0, 1,32'h3000,0,32'h6FFC));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h6FFC,0,32'h7000));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h7000,1,32'h7004));
    // fill, then reset mid-stream
    vecs.push_back(mk(1,0,0,0,0, 1,32'h7000,1,32'h7008));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h7000,1,32'h700C));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h7000,1,32'h7010));
    vecs.push_back(mk(1,0,0,0,0, 1,32'h7000,1,32'h7010));
    vecs.push_back(mk(0,0,0,0,0, 0,32'h0,   0,32'h3000));
    vecs.push_back(mk(1,1,0,0,0, 1,32'h3000,0,32'h3004));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].rdy, vecs[i].rv, vecs[i].rpc, vecs[i].ev);
      chk_out($sformatf("ds1 v%0d", i), d1_valid, d1_pc, d1_pc8, d1_instr,
              d1_adel, d1_addr, vecs[i].e_valid, vecs[i].e_pc,
              vecs[i].e_adel, vecs[i].e_addr);
    end

    // no delay slot: redirect flushes the waiting head as well
    drive(0,1,0,32'h0,0);
    chk_out("ds0 reset", d0_valid, d0_pc, d0_pc8, d0_instr, d0_adel, d0_addr,
            1'b0, 32'h0, 1'b0, 32'h3000);
    for (int i = 0; i < 4; i++) begin
      drive(1,1,0,32'h0,0);
      chk_out($sformatf("ds0 run%0d", i), d0_valid, d0_pc, d0_pc8, d0_instr,
              d0_adel, d0_addr, 1'b1, 32'h3000 + 32'(4*i), 1'b0,
              32'h3004 + 32'(4*i));
    end
    drive(1,0,1,32'h3100,0);
    chk_out("ds0 redirect", d0_valid, d0_pc, d0_pc8, d0_instr, d0_adel, d0_addr,
            1'b0, 32'h0, 1'b0, 32'h3100);
    drive(1,1,0,32'h0,0);
    chk_out("ds0 target", d0_valid, d0_pc, d0_pc8, d0_instr, d0_adel, d0_addr,
            1'b1, 32'h3100, 1'b0, 32'h3104);
    drive(1,1,0,32'h0,0);
    chk_out("ds0 target+4", d0_valid, d0_pc, d0_pc8, d0_instr, d0_adel, d0_addr,
            1'b1, 32'h3104, 1'b0, 32'h3108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
